ipd_scheduler: RTL
==================

IPD_SCHEDULER -- requirements
Module: ipd_scheduler

Interface
REQ-001 The block SHALL provide parameter cant_bits, default 16, data word width (signed Q8.8).
REQ-002 The block SHALL provide parameter PERIOD, default 1000, clock cycles between sample ticks (>= LATENCY+4).
REQ-003 The block SHALL provide parameter LATENCY, default 15, cycles from en pulse to valid salida.
REQ-004 The block SHALL provide port clk  in  1  single system clock, all logic on rising edge.
REQ-005 The block SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL provide port run  in  1  level; 1 enables sample ticks.
REQ-007 The block SHALL provide port adc_valid  in  1  one-cycle strobe, adc_data valid.
REQ-008 The block SHALL provide port adc_data  in  cant_bits  position sample.
REQ-009 The block SHALL provide port ref_in  in  cant_bits  setpoint, may change any cycle.
REQ-010 The block SHALL provide port salida  in  cant_bits  IPD datapath result.
REQ-011 The block SHALL provide port Pot  out  cant_bits  registered position to IPD datapath.
REQ-012 The block SHALL provide port Ref  out  cant_bits  registered setpoint to IPD datapath.
REQ-013 The block SHALL provide port en  out  1  one-cycle start pulse to IPD datapath.
REQ-014 The block SHALL provide port duty  out  cant_bits  latched controller output.
REQ-015 The block SHALL provide port duty_valid  out  1  one-cycle strobe, duty updated.
REQ-016 The block SHALL provide port busy  out  1  high whenever state != IDLE.
REQ-017 The block SHALL provide port overrun  out  1  sticky flag, tick missed.

Function
REQ-018 Tick counter SHALL count 0..PERIOD-1 while run=1, wrap to 0, and assert internal tick when count == PERIOD-1; when run=0 it SHALL hold at 0 with no ticks.
REQ-019 FSM states SHALL be IDLE, WAIT_ADC, START, COMPUTE, LATCH.
REQ-020 IDLE -> WAIT_ADC on tick.
REQ-021 In WAIT_ADC, on adc_valid=1 the block SHALL load Pot<=adc_data and Ref<=ref_in in the same edge and go to START; adc_valid in any other state SHALL be ignored.
REQ-022 START SHALL drive en=1 for exactly one cycle, clear the latency counter, and go to COMPUTE.
REQ-023 COMPUTE SHALL count cycles and go to LATCH after LATENCY cycles following the en cycle.
REQ-024 LATCH SHALL register duty from salida, pulse duty_valid for one cycle, and return to IDLE.
REQ-025 Pot and Ref SHALL remain stable from START through LATCH.
REQ-026 A tick in any state other than IDLE SHALL set overrun and be dropped, with no effect on the sample in progress; overrun SHALL clear only on rst.
REQ-027 When run falls mid-sample, the sample in progress SHALL complete normally.
REQ-028 When tick and adc_valid coincide in IDLE, the block SHALL take the tick only and ignore adc_valid.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set state=IDLE, tick and latency counters=0, Pot=Ref=duty=0, en=duty_valid=busy=overrun=0.
REQ-030 Reset SHALL take priority over all events including a sample mid-flight, with no duty_valid issued for an aborted sample.

Configuration
REQ-031 With IPD_CLAMP_EN defined, LATCH SHALL clamp a negative signed salida to 0 before loading duty.
REQ-032 Without IPD_CLAMP_EN, duty SHALL equal salida bit-for-bit.

Verification
REQ-033 Scenario: PERIOD=40, run=1, adc_valid 3 cycles after tick with adc_data=0x4000, ref_in=0x4B00 -> Pot=0x4000 and Ref=0x4B00 latched, en one cycle, duty_valid exactly LATENCY+1 cycles after en.
REQ-034 Scenario: adc_valid withheld past the next tick -> overrun=1, sample still completes once adc_valid arrives, and the next tick is accepted normally.
REQ-035 Scenario: rst asserted during COMPUTE -> all outputs 0 next cycle, no duty_valid, and restart on the next tick.
REQ-036 Scenario: salida=0xFF00 (-1.0) -> duty=0x0000 with IPD_CLAMP_EN, duty=0xFF00 without.
REQ-037 Scenario: run dropped during WAIT_ADC, then adc_valid -> the sample completes, then no further ticks and busy=0.

Source files
------------

// File: rtl/ipd_scheduler.sv
// ipd_scheduler: sample-tick scheduler and handshake for an IPD datapath.
// Ports: clk, rst (sync, active-high), run, adc_valid/adc_data, ref_in,
//   salida <- datapath result; Pot/Ref/en -> datapath; duty/duty_valid,
//   busy, overrun (sticky) status. Optional: IPD_CLAMP_EN clamps
//   negative results to 0.
module ipd_scheduler #(
    parameter int cant_bits = 16,
    parameter int PERIOD    = 1000,
    parameter int LATENCY   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 adc_valid,
    input  logic [cant_bits-1:0] adc_data,
    input  logic [cant_bits-1:0] ref_in,
    input  logic [cant_bits-1:0] salida,
    output logic [cant_bits-1:0] Pot,
    output logic [cant_bits-1:0] Ref,
    output logic                 en,
    output logic [cant_bits-1:0] duty,
    output logic                 duty_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ADC,
        START,
        COMPUTE,
        LATCH
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            tick;
    logic [cant_bits-1:0] duty_nxt;

    assign tick = run && (tick_cnt == TW'(PERIOD - 1));

`ifdef IPD_CLAMP_EN
    // Negative (signed Q8.8) results are clamped to zero duty.
    assign duty_nxt = salida[cant_bits-1] ? '0 : salida;
`else
    assign duty_nxt = salida;
`endif

    // Free-running sample timebase; parked at 0 while run is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!run) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TW'(PERIOD - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // en and duty_valid are registered so each is high exactly during
    // the START and LATCH cycles respectively. duty is loaded on the
    // edge entering LATCH so it is valid together with duty_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            Pot        <= '0;
            Ref        <= '0;
            duty       <= '0;
            en         <= 1'b0;
            duty_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            en         <= 1'b0;
            duty_valid <= 1'b0;

            // A tick outside IDLE is dropped; only the flag records it.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state <= WAIT_ADC;
                        busy  <= 1'b1;
                    end
                end
                WAIT_ADC: begin
                    if (adc_valid) begin
                        Pot   <= adc_data;
                        Ref   <= ref_in;
                        en    <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    lat_cnt <= '0;
                    state   <= COMPUTE;
                end
                COMPUTE: begin
                    if (lat_cnt == LW'(LATENCY - 1)) begin
                        duty       <= duty_nxt;
                        duty_valid <= 1'b1;
                        state      <= LATCH;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
